// File: rtl/pmem_burst_writer_if.sv
// AXI4 write-only channel bundle (AW, W, B) shared by the packet-memory
// data movers and their slaves.
interface taxi_axi_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 1
) ();
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport wr_mst (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport wr_slv (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/pmem_burst_writer.sv
// AXI4 burst write master for the packet-memory data mover: splits a
// (address, word count) command into INCR bursts, one outstanding at a time.
module pmem_burst_writer #(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 32,
  parameter int LEN_W         = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic              busy,
  output logic              done,
  output logic              error,
  taxi_axi_if.wr_mst        m_axi_wr
);

  localparam int BPB  = DATA_W / 8;
  localparam int SIZE = $clog2(BPB);
  localparam int CW   = (LEN_W > 13) ? LEN_W : 13;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BPB - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_AW   = 3'd2;
  localparam logic [2:0] ST_W    = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [8:0]        beats;
  logic [8:0]        beat_cnt;
  logic              error_q;
  logic [8:0]        calc_beats;
  logic [12:0]       room;
  logic [CW-1:0]     lim;
  logic [ADDR_W-1:0] burst_bytes;

  // Burst size is the smallest of what is left, the burst cap, and the
  // beats remaining before the next 4 KB page boundary.
  always_comb begin
    room = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE;
    lim  = CW'(MAX_BURST_LEN);
    if (CW'(room) < lim)      lim = CW'(room);
    if (CW'(remaining) < lim) lim = CW'(remaining);
    calc_beats = 9'(lim);
  end

  assign burst_bytes = ADDR_W'(beats) << SIZE;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      beats     <= '0;
      beat_cnt  <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr & ALIGN_MASK;
            remaining <= cmd_len;
            error_q   <= 1'b0;
            state     <= (cmd_len == '0) ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          beats <= calc_beats;
          state <= ST_AW;
        end
        ST_AW: begin
          if (m_axi_wr.awready) begin
            beat_cnt <= beats;
            state    <= ST_W;
          end
        end
        ST_W: begin
          if (s_tvalid && m_axi_wr.wready) begin
            beat_cnt <= beat_cnt - 9'd1;
            if (beat_cnt == 9'd1) state <= ST_B;
          end
        end
        ST_B: begin
          // A failed burst is recorded but the rest of the command still runs.
          if (m_axi_wr.bvalid) begin
            if (m_axi_wr.bresp != 2'b00) error_q <= 1'b1;
            addr      <= addr + burst_bytes;
            remaining <= remaining - LEN_W'(beats);
            state     <= (remaining == LEN_W'(beats)) ? ST_DONE : ST_CALC;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_CALC) || (state == ST_AW) || (state == ST_W) || (state == ST_B);
  assign done      = (state == ST_DONE);
  assign error     = error_q;

  assign m_axi_wr.awid    = '0;
  assign m_axi_wr.awaddr  = addr;
  assign m_axi_wr.awlen   = 8'(beats - 9'd1);
  assign m_axi_wr.awsize  = 3'(SIZE);
  assign m_axi_wr.awburst = 2'b01;
  assign m_axi_wr.awlock  = 1'b0;
  assign m_axi_wr.awcache = 4'b0011;
  assign m_axi_wr.awprot  = 3'b000;
  assign m_axi_wr.awqos   = 4'b0000;
  assign m_axi_wr.awvalid = (state == ST_AW);

  // Write data flows straight through so a stall on either side costs no buffering.
  assign m_axi_wr.wdata  = s_tdata;
  assign m_axi_wr.wstrb  = '1;
  assign m_axi_wr.wlast  = (state == ST_W) && (beat_cnt == 9'd1);
  assign m_axi_wr.wvalid = (state == ST_W) && s_tvalid;
  assign s_tready        = (state == ST_W) && m_axi_wr.wready;

  assign m_axi_wr.bready = (state == ST_B);

endmodule
